jtag_host_driver: RTL and testbench

//  Host-side JTAG master, directly upstream of the TAP/boundary-scan top: it feeds the top's tck/tms/tdi/trst pins and consumes tdo.

---
 rtl/jtag_host_driver_pkg.sv | 29 ++
 rtl/jtag_host_driver_tck_gen.sv | 41 ++++
 rtl/jtag_host_driver.sv | 207 ++++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_driver_pkg.sv
// Shared command/state types and TAP navigation constants for the JTAG host driver.
package jtag_pkg;

    typedef enum logic [1:0] {
        TAP_RESET = 2'd0,
        SHIFT_IR  = 2'd1,
        SHIFT_DR  = 2'd2
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_NAV_IN,
        ST_SHIFT,
        ST_NAV_OUT,
        ST_RESP,
        ST_RST_SEQ
    } state_e;

    localparam int unsigned NAV_IR_LEN  = 4;
    localparam int unsigned NAV_DR_LEN  = 3;
    localparam int unsigned NAV_OUT_LEN = 2;
    localparam int unsigned RST_SEQ_LEN = 6;

    // bit i = tms on navigation TCK i when walking RTI -> Shift-IR / Shift-DR
    localparam logic [3:0] NAV_IR_TMS = 4'b0011;
    localparam logic [3:0] NAV_DR_TMS = 4'b0001;

endpackage

// File: rtl/jtag_host_driver_tck_gen.sv
// TCK divider: CLK_DIV clk low, CLK_DIV clk high while enabled, low when idle.
// The strobes are asserted in the clk cycle whose closing edge toggles tck.
module jtag_tck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int unsigned   PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_phase;
    logic          r_tck;
    logic          w_edge;

    assign w_edge     = i_en && (r_phase == PH_LAST);
    assign o_rise_stb = w_edge && !r_tck;
    assign o_fall_stb = w_edge && r_tck;
    assign o_tck      = r_tck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_tck   <= 1'b0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_tck   <= 1'b0;
        end else if (w_edge) begin
            r_phase <= '0;
            r_tck   <= ~r_tck;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// Host-side JTAG master: turns TAP-reset / IR-scan / DR-scan commands into
// tck/tms/tdi/trst_n sequences and returns captured tdo bits, always parking in RTI.
module jtag_host_driver
    import jtag_pkg::*;
#(
    parameter  int unsigned CLK_DIV = 2,
    parameter  int unsigned MAX_LEN = 64,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               trst_n,
    input  logic               tdo
);

    state_e             r_state, w_state_nxt;
    logic [2:0]         r_step, w_step_nxt;
    logic [LEN_W-1:0]   r_bits, w_bits_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic               r_is_ir, w_is_ir_nxt;
    logic [MAX_LEN-1:0] r_data, w_data_nxt;
    logic [MAX_LEN-1:0] r_rsp, w_rsp_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic               r_tms, w_tms_nxt;
    logic               r_tdi, w_tdi_nxt;
    logic               r_trst_n, w_trst_n_nxt;

    logic               w_tck_en, w_rise, w_fall;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [2:0]         w_step_inc, w_nav_last;
    logic [3:0]         w_nav_pat;

    assign w_tck_en    = (r_state == ST_BOOT) || (r_state == ST_RST_SEQ) || (r_state == ST_NAV_IN) ||
                         (r_state == ST_SHIFT) || (r_state == ST_NAV_OUT);
    assign w_len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign w_step_inc  = r_step + 3'd1;
    assign w_nav_last  = r_is_ir ? 3'(NAV_IR_LEN - 1) : 3'(NAV_DR_LEN - 1);
    assign w_nav_pat   = r_is_ir ? NAV_IR_TMS : NAV_DR_TMS;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_tck_en),
        .o_tck      (tck),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_step      <= '0;
            r_bits      <= '0;
            r_len       <= '0;
            r_is_ir     <= 1'b0;
            r_data      <= '0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst_n    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_bits      <= w_bits_nxt;
            r_len       <= w_len_nxt;
            r_is_ir     <= w_is_ir_nxt;
            r_data      <= w_data_nxt;
            r_rsp       <= w_rsp_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
            r_trst_n    <= w_trst_n_nxt;
        end
    end

    // tms/tdi for the next TCK are decided on the fall strobe that ends the current one
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_bits_nxt      = r_bits;
        w_len_nxt       = r_len;
        w_is_ir_nxt     = r_is_ir;
        w_data_nxt      = r_data;
        w_rsp_nxt       = r_rsp;
        w_rsp_valid_nxt = r_rsp_valid;
        w_tms_nxt       = r_tms;
        w_tdi_nxt       = r_tdi;
        w_trst_n_nxt    = r_trst_n;
        case (r_state)
            ST_BOOT, ST_RST_SEQ: begin
                if (w_fall) begin
                    w_trst_n_nxt = 1'b1;
                    if (r_step == 3'(RST_SEQ_LEN - 1)) begin
                        w_state_nxt = (r_state == ST_BOOT) ? ST_IDLE : ST_RESP;
                    end else begin
                        w_step_nxt = w_step_inc;
                        w_tms_nxt  = (w_step_inc != 3'(RST_SEQ_LEN - 1));
                    end
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_step_nxt = '0;
                    w_tms_nxt  = 1'b1;
                    w_tdi_nxt  = 1'b0;
                    w_data_nxt = cmd_data;
                    w_rsp_nxt  = '0;
                    w_len_nxt  = w_len_clamp;
                    w_bits_nxt = w_len_clamp;
                    case (cmd_op_e'(cmd_op))
                        SHIFT_IR: begin
                            w_state_nxt = ST_NAV_IN;
                            w_is_ir_nxt = 1'b1;
                        end
                        SHIFT_DR: begin
                            w_state_nxt = ST_NAV_IN;
                            w_is_ir_nxt = 1'b0;
                        end
                        default: begin
                            w_state_nxt  = ST_RST_SEQ;
                            w_trst_n_nxt = 1'b0;
                            w_len_nxt    = '0;
                            w_bits_nxt   = '0;
                        end
                    endcase
                end
            end
            ST_NAV_IN: begin
                if (w_fall) begin
                    if (r_step == w_nav_last) begin
                        w_step_nxt = '0;
                        if (r_bits == '0) begin
                            w_state_nxt = ST_NAV_OUT;
                            w_tms_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_SHIFT;
                            w_tms_nxt   = (r_bits == LEN_W'(1));
                            w_tdi_nxt   = r_data[0];
                        end
                    end else begin
                        // zero-length scan leaves Capture straight to Exit1
                        w_step_nxt = w_step_inc;
                        w_tms_nxt  = w_nav_pat[w_step_inc[1:0]] ||
                                     ((r_bits == '0) && (w_step_inc == w_nav_last));
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_rsp_nxt = {tdo, r_rsp[MAX_LEN-1:1]};
                end
                if (w_fall) begin
                    w_bits_nxt = r_bits - LEN_W'(1);
                    w_data_nxt = r_data >> 1;
                    if (r_bits == LEN_W'(1)) begin
                        w_state_nxt = ST_NAV_OUT;
                        w_tms_nxt   = 1'b1;
                        w_tdi_nxt   = 1'b0;
                    end else begin
                        w_tms_nxt = (r_bits == LEN_W'(2));
                        w_tdi_nxt = r_data[1];
                    end
                end
            end
            ST_NAV_OUT: begin
                if (w_fall) begin
                    if (r_step == 3'(NAV_OUT_LEN - 1)) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_step_nxt = w_step_inc;
                        w_tms_nxt  = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                if (!r_rsp_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_nxt       = r_rsp >> (MAX_LEN - 32'(r_len));
                end else if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign trst_n    = r_trst_n;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver: vector table of scan commands checked against a
// behavioural TAP with DR loopback, plus boot, back-pressure and mid-scan reset sequences.
module tb_jtag_host_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [6:0]  cmd_len = '0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        tck, tms, tdi, trst_n, tdo;

    always #5 clk = ~clk;

    jtag_host_driver #(.CLK_DIV(2), .MAX_LEN(64)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst_n    (trst_n),
        .tdo       (tdo)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDDR,
        SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPDIR
    } tap_e;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDDR : PAUSEDR;
            PAUSEDR: return m ? EX2DR : PAUSEDR;
            EX2DR:   return m ? UPDDR : SHDR;
            UPDDR:   return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPDIR : PAUSEIR;
            PAUSEIR: return m ? EX2IR : PAUSEIR;
            EX2IR:   return m ? UPDIR : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    // TAP with a single-bit DR: Capture-DR loads 0, Shift-DR shifts tdi through
    tap_e tap = TLR;
    logic loop_q = 1'b0;
    bit   tdo_loop = 1'b0;
    assign tdo = tdo_loop ? loop_q : 1'b1;

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap    <= TLR;
            loop_q <= 1'b0;
        end else begin
            if (tap == CAPDR)     loop_q <= 1'b0;
            else if (tap == SHDR) loop_q <= tdi;
            tap <= tap_next(tap, tms);
        end
    end

    int   tck_total = 0;
    logic tms_log  [0:1023];
    logic tdi_log  [0:1023];
    logic trst_log [0:1023];

    always @(posedge tck) begin
        tms_log[tck_total % 1024]  <= tms;
        tdi_log[tck_total % 1024]  <= tdi;
        trst_log[tck_total % 1024] <= trst_n;
        tck_total <= tck_total + 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_resets(input string name);
        chk({name, " tck"},       64'(tck),       64'd0);
        chk({name, " tms"},       64'(tms),       64'd1);
        chk({name, " tdi"},       64'(tdi),       64'd0);
        chk({name, " trst_n"},    64'(trst_n),    64'd0);
        chk({name, " cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({name, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({name, " rsp_data"},  rsp_data,       64'd0);
    endtask

    // Counts clk cycles from rst release until cmd_ready and checks the boot TAP reset
    task automatic check_boot(input string name);
        int n, t0, nt, low;
        logic [15:0] g_tms;
        bit saw_valid;
        t0 = tck_total;
        rst = 1'b0;
        n = 0;
        saw_valid = 1'b0;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) saw_valid = 1'b1;
        end
        nt = tck_total - t0;
        g_tms = '0;
        low = 0;
        for (int i = 0; i < 16; i++) if (i < nt) g_tms[i] = tms_log[(t0 + i) % 1024];
        for (int i = 0; i < nt && i < 1024; i++) if (!trst_log[(t0 + i) % 1024]) low++;
        chk({name, " boot clk"},  64'(n),         64'd24);
        chk({name, " boot tck"},  64'(nt),        64'd6);
        chk({name, " boot tms"},  64'(g_tms),     64'h001F);
        chk({name, " boot trst"}, 64'(low),       64'd1);
        chk({name, " boot tap"},  64'(tap),       64'(RTI));
        chk({name, " boot rsp"},  64'(saw_valid), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  len;
        logic [63:0] data;
        bit          loop;
        int          ntck;
        int          lat;
        logic [63:0] rsp;
        bit          chk_seq;
        logic [15:0] tms;
        logic [15:0] tdi;
        int          trst;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v, input int idx);
        int t0, nt, lat, low;
        logic [15:0] g_tms, g_tdi;
        string p;
        p = $sformatf("v%0d", idx);
        tdo_loop = v.loop;
        wait_ready(p);
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        t0 = tck_total;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_len   = ~v.len;
        cmd_data  = {$urandom, $urandom};
        chk({p, " ready busy"}, 64'(cmd_ready), 64'd0);
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        nt = tck_total - t0;
        chk({p, " latency"}, 64'(lat), 64'(v.lat));
        chk({p, " ntck"},    64'(nt),  64'(v.ntck));
        chk({p, " rsp"},     rsp_data, v.rsp);
        chk({p, " tap"},     64'(tap), 64'(RTI));
        low = 0;
        for (int i = 0; i < nt && i < 1024; i++) if (!trst_log[(t0 + i) % 1024]) low++;
        chk({p, " trst"}, 64'(low), 64'(v.trst));
        if (v.chk_seq) begin
            g_tms = '0;
            g_tdi = '0;
            for (int i = 0; i < 16; i++) begin
                if (i < nt) begin
                    g_tms[i] = tms_log[(t0 + i) % 1024];
                    g_tdi[i] = tdi_log[(t0 + i) % 1024];
                end
            end
            chk({p, " tms"}, 64'(g_tms), 64'(v.tms));
            chk({p, " tdi"}, 64'(g_tdi), 64'(v.tdi));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({p, " rsp drop"}, 64'(rsp_valid), 64'd0);
        chk({p, " ready"},    64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, t0;
        // op, len, data, loop, ntck, lat, rsp, chk_seq, tms, tdi, trst
        vecs[0] = '{2'd0, 7'd5,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6,  25,  64'h0,                   1'b1, 16'h001F, 16'h0000, 1};
        vecs[1] = '{2'd1, 7'd4,   64'h1,                   1'b0, 10, 41,  64'hF,                   1'b1, 16'h0183, 16'h0010, 0};
        vecs[2] = '{2'd2, 7'd32,  64'hA5A5_0F0F,           1'b1, 37, 149, 64'h4B4A_1E1E,           1'b0, 16'h0,    16'h0,    0};
        vecs[3] = '{2'd2, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5,  21,  64'h0,                   1'b1, 16'h000D, 16'h0000, 0};
        vecs[4] = '{2'd3, 7'd8,   64'h00FF,                1'b0, 6,  25,  64'h0,                   1'b1, 16'h001F, 16'h0000, 1};
        vecs[5] = '{2'd1, 7'd0,   64'h3,                   1'b0, 6,  25,  64'h0,                   1'b1, 16'h001B, 16'h0000, 0};
        vecs[6] = '{2'd2, 7'd100, 64'h0123_4567_89AB_CDEF, 1'b1, 69, 277, 64'h0246_8ACF_1357_9BDE, 1'b0, 16'h0,    16'h0,    0};
        vecs[7] = '{2'd2, 7'd1,   64'h1,                   1'b0, 6,  25,  64'h1,                   1'b1, 16'h0019, 16'h0008, 0};
        vecs[8] = '{2'd1, 7'd64,  64'h0,                   1'b0, 70, 281, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'h0,    16'h0,    0};
        vecs[9] = '{2'd2, 7'd64,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 69, 277, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 16'h0,    16'h0,    0};

        repeat (3) @(posedge clk);
        #1;
        check_resets("reset");
        check_boot("init");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // response back-pressure: response held, new commands refused
        tdo_loop = 1'b0;
        wait_ready("bp");
        cmd_op = 2'd1; cmd_len = 7'd4; cmd_data = 64'h1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp first valid", 64'(rsp_valid), 64'd1);
        t0 = tck_total;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd8; cmd_data = 64'hFF;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp valid", 64'(rsp_valid), 64'd1);
            chk("bp data",  rsp_data,       64'hF);
            chk("bp ready", 64'(cmd_ready), 64'd0);
        end
        chk("bp no tck", 64'(tck_total - t0), 64'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp ready after", 64'(cmd_ready), 64'd1);
        chk("bp valid after", 64'(rsp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp stays idle", 64'(tck_total - t0), 64'd0);

        // reset in the middle of shift bit 10 of a DR scan
        tdo_loop = 1'b1;
        wait_ready("mid");
        cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = 64'hA5A5_0F0F; cmd_valid = 1'b1;
        t0 = tck_total;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while ((tck_total - t0) < 14 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid reached bit10", 64'(tck_total - t0), 64'd14);
        #2 rst = 1'b1;
        #1;
        check_resets("mid reset");
        repeat (2) @(posedge clk);
        #1;
        check_boot("mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
